// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset/lock sequencer with retry, fault and core reset generation.
// Optional lock-loss event counter enabled by defining PLL_LOSS_COUNT_EN.
module pll_lock_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       req_restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int CW0 = (PW > SW) ? PW : SW;
  localparam int CW = (CW0 > TW) ? CW0 : TW;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    retry_n;
  logic          lock_meta, lock_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // One counter serves the pulse, timeout and stable phases; every state entry reloads it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    retry_n = retry_cnt;
    if (req_restart) begin
      state_n = RESET_PLL;
      cnt_n   = '0;
      retry_n = 4'd0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (cnt == TO_LAST) begin
            retry_n = retry_cnt + 4'd1;
            cnt_n   = '0;
            state_n = (retry_cnt + 4'd1 == RETRY_MAX) ? FAULT : RESET_PLL;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = READY;
            cnt_n   = '0;
            retry_n = 4'd0;
          end
        end
        READY: begin
          cnt_n   = '0;
          retry_n = 4'd0;
          if (!lock_s) state_n = RESET_PLL;
        end
        FAULT: begin
          cnt_n = '0;
        end
        default: begin
          state_n = RESET_PLL;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_PLL;
      cnt        <= '0;
      retry_cnt  <= 4'd0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      pll_rst    <= (state_n == RESET_PLL) || (state_n == FAULT);
      core_reset <= (state_n != READY);
      ready      <= (state_n == READY);
      fault      <= (state_n == FAULT);
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic       loss_evt;
  logic [7:0] loss_q;

  assign loss_evt = (state == READY) && !lock_s && !req_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
